// File: rtl/vga_capture_pkg.sv
// Shared constants and types for the VGA capture block.
// Holds the nominal 640x480@60 timing, the default bus widths, the capture
// FSM state encoding and a helper that totals one timing axis.
package vga_capture_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int DATA_W_DEF   = 12;
    localparam int ADDR_W_DEF   = 19;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_MEASURE  = 2'd1,
        ST_LOCKED   = 2'd2
    } cap_state_t;

    // Full period of one axis (pixels per line or lines per frame).
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_capture_if.sv
// Frame-buffer write port of the VGA capture block.
//   wr_en       write strobe
//   wr_addr     linear pixel address, y*H_ACTIVE+x
//   wr_data     pixel value
//   frame_start pulses with the write of address 0
//   frame_done  pulses with the write of the last address of the frame
// master: the capture block; slave: the frame-buffer RAM side.
interface vga_capture_if
    import vga_capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_start;
    logic              frame_done;

    modport master (output wr_en, wr_addr, wr_data, frame_start, frame_done);
    modport slave  (input  wr_en, wr_addr, wr_data, frame_start, frame_done);
endinterface

// File: rtl/vga_capture_sync_edge.sv
// Two-stage register for an active-low sync input plus a falling-edge pulse.
//   clk, rst  pixel clock, asynchronous active-high reset (stages reset to 1)
//   din       raw sync input
//   fall      high while the newer stage is 0 and the older stage is 1
module vga_capture_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall
);
    logic s1;
    logic s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    assign fall = s2 & ~s1;
endmodule

// File: rtl/vga_capture.sv
// VGA receive side: locks to incoming hsync/vsync timing and writes every
// active pixel of armed frames into the frame buffer.
//   clk, rst    pixel clock, asynchronous active-high reset
//   hsync/vsync incoming syncs, active low
//   rgb_in      incoming pixel
//   capture_en  frame enable, latched at each frame start while locked
//   fb          frame-buffer write port (master)
//   locked      timing verified over a full clean frame
//   sync_err    one-cycle pulse per timing violation while measuring/locked
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [DATA_W-1:0] rgb_in,
    input  logic              capture_en,
    vga_capture_if.master     fb,
    output logic              locked,
    output logic              sync_err
);
    localparam int H_TOTAL      = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL      = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HP_W         = $clog2(H_TOTAL + 1);
    localparam int VL_W         = $clog2(V_TOTAL + 1);
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

    localparam logic [HP_W-1:0]   H_END    = HP_W'(H_TOTAL);
    localparam logic [HP_W-1:0]   H_LAST   = HP_W'(H_TOTAL - 1);
    localparam logic [HP_W-1:0]   H_ACT_LO = HP_W'(H_SYNC + H_BP);
    localparam logic [HP_W-1:0]   H_ACT_HI = HP_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [VL_W-1:0]   V_END    = VL_W'(V_TOTAL);
    localparam logic [VL_W-1:0]   V_LAST   = VL_W'(V_TOTAL - 1);
    localparam logic [VL_W-1:0]   V_ACT_LO = VL_W'(V_SYNC + V_BP);
    localparam logic [VL_W-1:0]   V_ACT_HI = VL_W'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(FRAME_PIXELS - 1);

    logic              hfall_p0;
    logic              vfall_p0;
    logic [DATA_W-1:0] pix_p0;

    cap_state_t        state_q;
    logic              meas_err_q;
    logic              arm_q;
    logic [ADDR_W-1:0] addr_q;
    logic [HP_W-1:0]   hpos_q;
    logic [VL_W-1:0]   vline_q;
    logic              vpend_q;

    logic [HP_W-1:0]   hpos_p0;
    logic [VL_W-1:0]   vline_p0;
    logic              vzero_p0;
    logic              viol_p0;
    logic              active_p0;
    logic              write_p0;

    // Stage p0: syncs and pixel registered together so edges stay aligned with data.
    vga_capture_sync_edge u_hs (.clk(clk), .rst(rst), .din(hsync), .fall(hfall_p0));
    vga_capture_sync_edge u_vs (.clk(clk), .rst(rst), .din(vsync), .fall(vfall_p0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pix_p0 <= '0;
        else     pix_p0 <= rgb_in;
    end

    // Position of the pixel now in stage p0 and the timing checks it completes.
    // hpos_q/vline_q hold the position of the previous pixel.
    always_comb begin
        hpos_p0  = hpos_q;
        vline_p0 = vline_q;
        vzero_p0 = 1'b0;
        viol_p0  = 1'b0;
        if (hfall_p0) begin
            hpos_p0  = '0;
            viol_p0  = (hpos_q != H_LAST);
            vzero_p0 = vpend_q | vfall_p0;
            if (vzero_p0) begin
                vline_p0 = '0;
                if (vline_q != V_LAST) viol_p0 = 1'b1;
            end else if (vline_q != V_END) begin
                vline_p0 = vline_q + VL_W'(1);
            end
        end else if (hpos_q != H_END) begin
            hpos_p0 = hpos_q + HP_W'(1);
            // Line ran past its nominal length: flag once, when the count saturates.
            if (hpos_q == H_LAST) viol_p0 = 1'b1;
        end
        active_p0 = (hpos_p0 >= H_ACT_LO) && (hpos_p0 <= H_ACT_HI) &&
                    (vline_p0 >= V_ACT_LO) && (vline_p0 <= V_ACT_HI);
        // A violation suppresses the write in the same cycle that locked drops.
        write_p0  = (state_q == ST_LOCKED) && arm_q && active_p0 && !viol_p0;
    end

    // Stage p1: counters, lock FSM and frame-buffer outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hpos_q         <= '0;
            vline_q        <= '0;
            vpend_q        <= 1'b0;
            state_q        <= ST_UNLOCKED;
            meas_err_q     <= 1'b0;
            arm_q          <= 1'b0;
            addr_q         <= '0;
            locked         <= 1'b0;
            sync_err       <= 1'b0;
            fb.wr_en       <= 1'b0;
            fb.wr_addr     <= '0;
            fb.wr_data     <= '0;
            fb.frame_start <= 1'b0;
            fb.frame_done  <= 1'b0;
        end else begin
            hpos_q  <= hpos_p0;
            vline_q <= vline_p0;
            // Remember a vsync fall until the hsync fall that starts the line.
            vpend_q <= hfall_p0 ? 1'b0 : (vpend_q | vfall_p0);

            sync_err       <= viol_p0 && (state_q != ST_UNLOCKED);
            fb.wr_en       <= write_p0;
            fb.frame_start <= write_p0 && (addr_q == '0);
            fb.frame_done  <= write_p0 && (addr_q == A_LAST);
            if (write_p0) begin
                fb.wr_addr <= addr_q;
                fb.wr_data <= pix_p0;
                if (addr_q != A_LAST) addr_q <= addr_q + ADDR_W'(1);
            end

            case (state_q)
                ST_UNLOCKED: begin
                    if (vzero_p0) begin
                        state_q    <= ST_MEASURE;
                        meas_err_q <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (vzero_p0) begin
                        if (meas_err_q || viol_p0) begin
                            meas_err_q <= 1'b0;
                        end else begin
                            state_q <= ST_LOCKED;
                            locked  <= 1'b1;
                            arm_q   <= capture_en;
                            addr_q  <= '0;
                        end
                    end else if (viol_p0) begin
                        meas_err_q <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (viol_p0) begin
                        state_q <= ST_UNLOCKED;
                        locked  <= 1'b0;
                    end else if (vzero_p0) begin
                        arm_q  <= capture_en;
                        addr_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_UNLOCKED;
                    locked  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_capture.sv
module tb_vga_capture;
    localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 4, H_BP = 3;
    localparam int V_ACTIVE = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int DATA_W = 12, ADDR_W = 19;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_LO = H_SYNC + H_BP;
    localparam int V_LO = V_SYNC + V_BP;
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              fs;
        logic              fd;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hsync = 1'b1;
    logic              vsync = 1'b1;
    logic [DATA_W-1:0] rgb_in = '0;
    logic              capture_en = 1'b0;
    logic              locked;
    logic              sync_err;

    vga_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fb();

    vga_capture #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb_in(rgb_in),
        .capture_en(capture_en), .fb(fb), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    wr_t exp_q[$];
    int  err_seen = 0, fs_seen = 0, fd_seen = 0;

    // Frame-level reference model of the lock behaviour.
    bit  m_locked = 0, m_measuring = 0, m_bad = 0, m_arm = 0;
    int  m_addr = 0, m_exp_err = 0, fs_exp = 0, fd_exp = 0;
    int  prev_lines = 0, prev_len = H_TOTAL;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void model_violation();
        if (m_locked) begin
            m_locked = 0;
            m_exp_err++;
        end else if (m_measuring) begin
            m_bad = 1;
            m_exp_err++;
        end
    endfunction

    function automatic void model_frame_boundary(input bit bad);
        if (m_locked) begin
            if (bad) begin
                m_exp_err++;
                m_locked = 0;
            end else begin
                m_arm  = capture_en;
                m_addr = 0;
            end
        end else if (m_measuring) begin
            if (bad) m_exp_err++;
            if (m_bad || bad) begin
                m_bad = 0;
            end else begin
                m_measuring = 0;
                m_locked    = 1;
                m_arm       = capture_en;
                m_addr      = 0;
            end
        end else begin
            m_measuring = 1;
            m_bad       = 0;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_locked", 64'(locked), 64'(0));
        check("rst_wr_en", 64'(fb.wr_en), 64'(0));
        check("rst_wr_addr", 64'(fb.wr_addr), 64'(0));
        check("rst_wr_data", 64'(fb.wr_data), 64'(0));
        check("rst_sync_err", 64'(sync_err), 64'(0));
        check("rst_frame_start", 64'(fb.frame_start), 64'(0));
        check("rst_frame_done", 64'(fb.frame_done), 64'(0));
        exp_q.delete();
        m_locked = 0; m_measuring = 0; m_bad = 0; m_arm = 0; m_addr = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        prev_lines = V_TOTAL;
        prev_len   = H_TOTAL;
    endtask

    // One frame; odd_line gets length odd_len, capture_en switches to cap1 at
    // cap_line, and reset is asserted mid-line rst_line.
    task automatic send_frame(input int nlines, input int odd_line, input int odd_len,
                              input bit cap0, input int cap_line, input bit cap1,
                              input int rst_line, input bit use_xor);
        logic [DATA_W-1:0] pix;
        capture_en = cap0;
        for (int v = 0; v < nlines; v++) begin
            int len;
            len = (v == odd_line) ? odd_len : H_TOTAL;
            if (v == cap_line) capture_en = cap1;
            if (v == 0) model_frame_boundary((prev_lines != V_TOTAL) || (prev_len != H_TOTAL));
            else if (prev_len != H_TOTAL) model_violation();
            for (int h = 0; h < len; h++) begin
                @(negedge clk);
                if (v == rst_line && h == H_LO + 5) begin
                    check("pre_rst_locked", 64'(locked), 64'(1));
                    do_reset();
                    return;
                end
                if (h == H_SYNC + 1) begin
                    check($sformatf("locked_v%0d", v), 64'(locked), 64'(m_locked));
                    check($sformatf("sync_err_count_v%0d", v), 64'(err_seen), 64'(m_exp_err));
                    if (v == nlines - 1)
                        check("pending_writes_at_frame_end", 64'(exp_q.size()), 64'(0));
                end
                hsync = (h < H_SYNC) ? 1'b0 : 1'b1;
                vsync = (v < V_SYNC) ? 1'b0 : 1'b1;
                if (use_xor && h >= H_LO && h < H_LO + H_ACTIVE)
                    pix = DATA_W'((h - H_LO) ^ (v - V_LO));
                else
                    pix = DATA_W'($urandom);
                rgb_in = pix;
                if (h >= H_LO && h < H_LO + H_ACTIVE && v >= V_LO && v < V_LO + V_ACTIVE
                    && m_locked && m_arm) begin
                    exp_q.push_back('{ADDR_W'(m_addr), pix, m_addr == 0, m_addr == FRAME_PIXELS - 1});
                    if (m_addr == 0) fs_exp++;
                    if (m_addr == FRAME_PIXELS - 1) fd_exp++;
                    if (m_addr < FRAME_PIXELS - 1) m_addr++;
                end
                if (h == H_TOTAL) model_violation();
            end
            prev_len = len;
        end
        prev_lines = nlines;
    endtask

    // Scoreboard monitor.
    initial begin
        wr_t a;
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sync_err) err_seen++;
                if (fb.frame_start) fs_seen++;
                if (fb.frame_done) fd_seen++;
                a = '{fb.wr_addr, fb.wr_data, fb.frame_start, fb.frame_done};
                if (fb.wr_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write addr=%0d data=%0h required=no_write",
                                 fb.wr_addr, fb.wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (a !== e) begin
                            failures++;
                            $display("FAIL write addr=%0d data=%0h fs=%0b fd=%0b required addr=%0d data=%0h fs=%0b fd=%0b",
                                     a.addr, a.data, a.fs, a.fd, e.addr, e.data, e.fs, e.fd);
                        end
                    end
                end else if (fb.frame_start || fb.frame_done) begin
                    checks++;
                    failures++;
                    $display("FAIL strobe_without_write fs=%0b fd=%0b required=0", fb.frame_start, fb.frame_done);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("init_locked", 64'(locked), 64'(0));
        check("init_wr_en", 64'(fb.wr_en), 64'(0));
        check("init_sync_err", 64'(sync_err), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        // measure, then first captured frame
        send_frame(V_TOTAL, -1, 0, 1, -1, 0, -1, 1);
        send_frame(V_TOTAL, -1, 0, 1, -1, 0, -1, 1);
        // short line while locked, then relock
        send_frame(V_TOTAL, V_LO + 3, H_TOTAL - 1, 1, -1, 0, -1, 0);
        send_frame(V_TOTAL, -1, 0, 1, -1, 0, -1, 0);
        send_frame(V_TOTAL, -1, 0, 1, -1, 0, -1, 0);
        // capture disabled at frame start, enabled mid-frame, then normal
        send_frame(V_TOTAL, -1, 0, 0, V_LO + 2, 1, -1, 0);
        send_frame(V_TOTAL, -1, 0, 1, -1, 0, -1, 0);
        // hsync stuck high past the line length
        send_frame(V_TOTAL, V_LO + 4, H_TOTAL + 12, 1, -1, 0, -1, 0);
        send_frame(V_TOTAL, -1, 0, 1, -1, 0, -1, 0);
        // one line short of a full frame, detected at the next frame start
        send_frame(V_TOTAL - 1, -1, 0, 1, -1, 0, -1, 0);
        send_frame(V_TOTAL, -1, 0, 1, -1, 0, -1, 0);
        // bad line during measurement delays the lock by a frame
        send_frame(V_TOTAL, V_LO + 1, H_TOTAL - 1, 1, -1, 0, -1, 0);
        send_frame(V_TOTAL, -1, 0, 1, -1, 0, -1, 0);
        // reset in the middle of a captured frame, then one frame after it
        send_frame(V_TOTAL, -1, 0, 1, -1, 0, V_LO + 4, 0);
        send_frame(V_TOTAL, -1, 0, 1, -1, 0, -1, 0);
        repeat (10) @(negedge clk);
        check("final_pending_writes", 64'(exp_q.size()), 64'(0));
        check("frame_start_count", 64'(fs_seen), 64'(fs_exp));
        check("frame_done_count", 64'(fd_seen), 64'(fd_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
